// File: rtl/ram_burst_pkg.sv
// Shared state encodings, default parameter values and the burst-length helper
// used by ram_burst and its storage array.
package ram_burst_pkg;

    typedef enum logic [1:0] {
        RAM_IDLE = 2'd0,
        RAM_WAIT = 2'd1,
        RAM_XFER = 2'd2,
        RAM_DONE = 2'd3
    } ram_state_t;

    localparam int DEF_DATA_W      = 32;
    localparam int DEF_ADDR_W      = 64;
    localparam int DEF_DEPTH_LOG2  = 10;
    localparam int DEF_WAIT_CYCLES = 2;
    localparam int DEF_MAX_BURST   = 16;

    // A zero-length request still moves one beat; oversize requests are capped.
    function automatic int unsigned eff_len(input int unsigned len, input int unsigned max_burst);
        if (len == 0) return 1;
        if (len > max_burst) return max_burst;
        return len;
    endfunction

endpackage

// File: rtl/ram_array.sv
// Word-organised storage for ram_burst: byte-masked synchronous write and a
// registered read port whose output register clears on reset.
module ram_array
    import ram_burst_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [DEPTH_LOG2-1:0] i_addr,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [DATA_W/8-1:0]   i_be,
    output logic [DATA_W-1:0]     o_rdata
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [2**DEPTH_LOG2];
    logic [DATA_W-1:0] r_rdata;

    // Contents are deliberately never cleared; only the read register is.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < NB; b++) begin
                if (i_be[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_rdata <= '0;
        else if (i_re) r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_burst.sv
// Burst-capable system-memory model: request/ready handshake, programmable wait
// states, wrapping bursts and per-byte write enables in front of ram_array.
module ram_burst
    import ram_burst_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DEPTH_LOG2  = DEF_DEPTH_LOG2,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int MAX_BURST   = DEF_MAX_BURST
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       req,
    input  logic                       write,
    input  logic [ADDR_W-1:0]          address,
    input  logic [$clog2(MAX_BURST):0] burst_len,
    input  logic [DATA_W-1:0]          data_in,
    input  logic [DATA_W/8-1:0]        byte_en,
    output logic                       busy,
    output logic                       wr_ready,
    output logic [DATA_W-1:0]          data_out,
    output logic                       data_valid,
    output logic                       done,
    output logic                       addr_err
);

    localparam int OFS    = $clog2(DATA_W / 8);
    localparam int LEN_W  = $clog2(MAX_BURST) + 1;
    localparam int WAIT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

    ram_state_t            r_state;
    ram_state_t            w_state_nxt;
    logic                  r_write;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic [LEN_W-1:0]      r_beats;
    logic [WAIT_W-1:0]     r_wait;
    logic                  r_addr_err;
    logic                  r_data_valid;
    logic [LEN_W-1:0]      w_eff_len;
    logic                  w_oor;
    logic                  w_accept;
    logic                  w_reject;
    logic                  w_we;
    logic                  w_re;
    logic                  w_unused_addr;

    // Low offset bits only select a byte within the word and are ignored.
    assign w_unused_addr = ^address;

    assign w_oor     = |(address >> (DEPTH_LOG2 + OFS));
    assign w_eff_len = LEN_W'(eff_len(32'(burst_len), 32'(MAX_BURST)));

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        case (r_state)
            RAM_IDLE: begin
                if (req) begin
                    if (w_oor) begin
                        w_reject = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_state_nxt = (WAIT_CYCLES > 0) ? RAM_WAIT : RAM_XFER;
                    end
                end
            end
            RAM_WAIT: if (r_wait == WAIT_W'(1)) w_state_nxt = RAM_XFER;
            RAM_XFER: if (r_beats == LEN_W'(1)) w_state_nxt = RAM_DONE;
            RAM_DONE: w_state_nxt = RAM_IDLE;
            default:  w_state_nxt = RAM_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) r_state <= RAM_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_addr_err   <= 1'b0;
            r_data_valid <= 1'b0;
        end else begin
            r_addr_err   <= w_reject;
            r_data_valid <= (r_state == RAM_XFER) && !r_write;
        end
    end

    // Transfer bookkeeping; the state register alone decides whether it matters.
    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_write <= write;
            r_idx   <= address[DEPTH_LOG2+OFS-1:OFS];
            r_beats <= w_eff_len;
            r_wait  <= WAIT_W'(WAIT_CYCLES);
        end else begin
            if (r_state == RAM_WAIT) r_wait <= r_wait - WAIT_W'(1);
            if (r_state == RAM_XFER) begin
                r_idx   <= r_idx + DEPTH_LOG2'(1);
                r_beats <= r_beats - LEN_W'(1);
            end
        end
    end

    // A beat coinciding with RESET is dropped so an aborted burst stops cleanly.
    assign w_we = (r_state == RAM_XFER) && r_write && !RESET;
    assign w_re = (r_state == RAM_XFER) && !r_write;

    ram_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .i_clk   (CLK),
        .i_rst   (RESET),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_addr  (r_idx),
        .i_wdata (data_in),
        .i_be    (byte_en),
        .o_rdata (data_out)
    );

    assign busy       = (r_state != RAM_IDLE);
    assign wr_ready   = (r_state == RAM_XFER) && r_write;
    assign done       = (r_state == RAM_DONE);
    assign addr_err   = r_addr_err;
    assign data_valid = r_data_valid;

endmodule

// File: tb/tb_ram_burst.sv
// Directed bench for ram_burst: a 1K-word/2-wait instance and a 16-word/0-wait
// instance share one request bus; each test follows the handshake of one of them.
module tb_ram_burst;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        write;
    logic [63:0] address;
    logic [4:0]  burst_len;
    logic [31:0] data_in;
    logic [3:0]  byte_en;

    logic        a_busy, a_wr_ready, a_data_valid, a_done, a_addr_err;
    logic [31:0] a_data_out;
    logic        b_busy, b_wr_ready, b_data_valid, b_done, b_addr_err;
    logic [31:0] b_data_out;

    logic [31:0] wbuf [16];
    logic [31:0] rbuf [16];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ram_burst #(
        .DATA_W(32), .ADDR_W(64), .DEPTH_LOG2(10), .WAIT_CYCLES(2), .MAX_BURST(16)
    ) u_dut_a (
        .CLK(clk), .RESET(rst), .req(req), .write(write), .address(address),
        .burst_len(burst_len), .data_in(data_in), .byte_en(byte_en),
        .busy(a_busy), .wr_ready(a_wr_ready), .data_out(a_data_out),
        .data_valid(a_data_valid), .done(a_done), .addr_err(a_addr_err)
    );

    ram_burst #(
        .DATA_W(32), .ADDR_W(64), .DEPTH_LOG2(4), .WAIT_CYCLES(0), .MAX_BURST(16)
    ) u_dut_b (
        .CLK(clk), .RESET(rst), .req(req), .write(write), .address(address),
        .burst_len(burst_len), .data_in(data_in), .byte_en(byte_en),
        .busy(b_busy), .wr_ready(b_wr_ready), .data_out(b_data_out),
        .data_valid(b_data_valid), .done(b_done), .addr_err(b_addr_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((a_busy || b_busy) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("idle_timeout", 32'(n), 32'(0));
        tick();
    endtask

    // One request on the shared bus, following instance sel (0=A, 1=B).
    task automatic xact(input string tag, input int sel, input bit wr,
                        input logic [63:0] addr, input logic [4:0] blen,
                        input logic [3:0] be, input int exp_n);
        int w, beats, first, done_c, c;
        logic bz, rdy, dv, dn;
        logic [31:0] dq;
        w      = (sel == 0) ? 2 : 0;
        beats  = 0;
        first  = -1;
        done_c = -1;
        req = 1'b1; write = wr; address = addr; burst_len = blen; byte_en = be;
        tick();
        req = 1'b0;
        bz = (sel == 0) ? a_busy : b_busy;
        chk({tag, "_busy"}, 32'(bz), 32'(1));
        c = 1;
        while (done_c < 0 && c <= 60) begin
            rdy = (sel == 0) ? a_wr_ready : b_wr_ready;
            dv  = (sel == 0) ? a_data_valid : b_data_valid;
            dn  = (sel == 0) ? a_done : b_done;
            dq  = (sel == 0) ? a_data_out : b_data_out;
            if (wr && rdy) begin
                if (first < 0) first = c;
                data_in = wbuf[4'(beats)];
                beats++;
            end
            if (!wr && dv) begin
                if (first < 0) first = c;
                rbuf[4'(beats)] = dq;
                beats++;
            end
            if (dn) done_c = c;
            else begin
                tick();
                c++;
            end
        end
        chk({tag, "_beats"}, 32'(beats), 32'(exp_n));
        chk({tag, "_first"}, 32'(first), wr ? 32'(1 + w) : 32'(2 + w));
        chk({tag, "_done"}, 32'(done_c), 32'(1 + w + exp_n));
        tick();
        bz = (sel == 0) ? a_busy : b_busy;
        chk({tag, "_idle"}, 32'(bz), 32'(0));
        wait_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, dvn, donec;
        rst = 1'b1; req = 1'b0; write = 1'b0; address = '0;
        burst_len = '0; data_in = '0; byte_en = '0;
        tick();
        tick();
        chk("rst_busy",   32'(a_busy), 32'(0));
        chk("rst_wrrdy",  32'(a_wr_ready), 32'(0));
        chk("rst_dout",   a_data_out, 32'h0);
        chk("rst_dvalid", 32'(a_data_valid), 32'(0));
        chk("rst_done",   32'(a_done), 32'(0));
        chk("rst_aerr",   32'(a_addr_err), 32'(0));
        chk("rst_b_busy", 32'(b_busy), 32'(0));
        rst = 1'b0;
        tick();

        // Single write then read, two wait states
        wbuf[0] = 32'hDEADBEEF;
        xact("a_wr40", 0, 1'b1, 64'h40, 5'd1, 4'hF, 1);
        xact("a_rd40", 0, 1'b0, 64'h40, 5'd1, 4'hF, 1);
        chk("a_rd40_data", rbuf[0], 32'hDEADBEEF);

        // Partial-word write over a known background
        wbuf[0] = 32'h11111111;
        xact("a_wr44", 0, 1'b1, 64'h44, 5'd1, 4'hF, 1);
        wbuf[0] = 32'hAABBCCDD;
        xact("a_wr44_be", 0, 1'b1, 64'h44, 5'd1, 4'h5, 1);
        xact("a_rd44", 0, 1'b0, 64'h44, 5'd1, 4'hF, 1);
        chk("a_rd44_data", rbuf[0], 32'h11BB11DD);

        // Length edges
        xact("a_len0", 0, 1'b0, 64'h40, 5'd0, 4'hF, 1);
        chk("a_len0_data", rbuf[0], 32'hDEADBEEF);
        for (int i = 0; i < 16; i++) wbuf[4'(i)] = 32'hB000_0000 + 32'(i);
        xact("a_wr_clamp", 0, 1'b1, 64'h200, 5'd21, 4'hF, 16);
        xact("a_rd_16", 0, 1'b0, 64'h200, 5'd16, 4'hF, 16);
        for (int i = 0; i < 16; i++) chk("a_rd_16_data", rbuf[4'(i)], 32'hB000_0000 + 32'(i));
        xact("a_rd_clamp", 0, 1'b0, 64'h200, 5'd21, 4'hF, 16);
        chk("a_rd_clamp_last", rbuf[15], 32'hB000_000F);

        // Out-of-range request
        req = 1'b1; write = 1'b0; address = 64'h1_0000_0000; burst_len = 5'd1;
        tick();
        req = 1'b0;
        chk("oor_aerr1", 32'(a_addr_err), 32'(1));
        chk("oor_busy1", 32'(a_busy), 32'(0));
        tick();
        chk("oor_aerr2", 32'(a_addr_err), 32'(0));
        chk("oor_busy2", 32'(a_busy), 32'(0));
        chk("oor_dvalid", 32'(a_data_valid), 32'(0));
        wait_idle();

        // req held high across a whole transfer
        dvn = 0;
        donec = -1;
        req = 1'b1; write = 1'b0; address = 64'h40; burst_len = 5'd1;
        tick();
        for (int c = 1; c <= 5; c++) begin
            if (a_data_valid) dvn++;
            if (a_done && donec < 0) donec = c;
            if (c == 5) chk("hold_idle_gap", 32'(a_busy), 32'(0));
            tick();
        end
        chk("hold_reaccept", 32'(a_busy), 32'(1));
        req = 1'b0;
        chk("hold_dvalid_cnt", 32'(dvn), 32'(1));
        chk("hold_done_cyc", 32'(donec), 32'(4));
        wait_idle();

        // RESET during beat 3 of an 8-beat write
        for (int i = 0; i < 8; i++) wbuf[4'(i)] = 32'h5A5A_0000 + 32'(i);
        xact("a_pre", 0, 1'b1, 64'h100, 5'd8, 4'hF, 8);
        for (int i = 0; i < 8; i++) wbuf[4'(i)] = 32'hC0DE_0000 + 32'(i);
        k = 0;
        req = 1'b1; write = 1'b1; address = 64'h100; burst_len = 5'd8; byte_en = 4'hF;
        tick();
        req = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (a_wr_ready) begin
                data_in = wbuf[4'(k)];
                k++;
            end
            if (c == 5) rst = 1'b1;
            tick();
        end
        chk("mid_rst_beats", 32'(k), 32'(3));
        chk("mid_rst_busy",   32'(a_busy), 32'(0));
        chk("mid_rst_wrrdy",  32'(a_wr_ready), 32'(0));
        chk("mid_rst_dout",   a_data_out, 32'h0);
        chk("mid_rst_dvalid", 32'(a_data_valid), 32'(0));
        chk("mid_rst_done",   32'(a_done), 32'(0));
        chk("mid_rst_aerr",   32'(a_addr_err), 32'(0));
        rst = 1'b0;
        xact("a_post_rst", 0, 1'b0, 64'h100, 5'd8, 4'hF, 8);
        chk("post_rst_w0", rbuf[0], 32'hC0DE_0000);
        chk("post_rst_w1", rbuf[1], 32'hC0DE_0001);
        for (int i = 2; i < 8; i++) chk("post_rst_keep", rbuf[4'(i)], 32'h5A5A_0000 + 32'(i));

        // Zero-wait instance: single beat and wrapping burst
        wbuf[0] = 32'h12345678;
        xact("b_wr08", 1, 1'b1, 64'h8, 5'd1, 4'hF, 1);
        xact("b_rd08", 1, 1'b0, 64'h8, 5'd1, 4'hF, 1);
        chk("b_rd08_data", rbuf[0], 32'h12345678);
        for (int i = 0; i < 4; i++) wbuf[4'(i)] = 32'(i + 1);
        xact("b_wr_wrap", 1, 1'b1, 64'h38, 5'd4, 4'hF, 4);
        xact("b_rd_wrap", 1, 1'b0, 64'h38, 5'd4, 4'hF, 4);
        for (int i = 0; i < 4; i++) chk("b_rd_wrap_data", rbuf[4'(i)], 32'(i + 1));
        xact("b_rd_w0", 1, 1'b0, 64'h0, 5'd2, 4'hF, 2);
        chk("b_word0", rbuf[0], 32'd3);
        chk("b_word1", rbuf[1], 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
